// File: rtl/ex_mem_stage_pkg.sv
// Shared constants for the EX/MEM stage: ALU op-codes, control-bundle bit positions,
// register-address width and the exception FSM state type.
package ex_mem_stage_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [5:0] ALU_SLL  = 6'b000001;
  localparam logic [5:0] ALU_SRL  = 6'b000010;
  localparam logic [5:0] ALU_SRA  = 6'b000011;
  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_ADDU = 6'b100001;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_SUBU = 6'b100011;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_SLT  = 6'b100110;

  // Bit positions inside the registered control bundle; CTRL_BRANCH holds branch & zero.
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_W          = 5;

  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef enum logic {
    EXC_IDLE    = 1'b0,
    EXC_PENDING = 1'b1
  } exc_state_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX -> MEM pipeline bus: EX-side operands and controls in, registered MEM-side copies out.
interface ex_mem_stage_if #(
  parameter int N          = 32,
  parameter int REG_ADDR_W = ex_mem_stage_pkg::REG_ADDR_W
);
  logic                  in_valid;
  logic [N-1:0]          alu_result;
  logic                  alu_zero;
  logic                  alu_overflow;
  logic                  ovf_trap_en;
  logic [N-1:0]          pc;
  logic [N-1:0]          store_data;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic                  reg_write;
  logic                  mem_read;
  logic                  mem_write;
  logic                  mem_to_reg;
  logic                  branch;

  logic                  out_valid;
  logic [N-1:0]          out_result;
  logic                  out_zero;
  logic [N-1:0]          out_store_data;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_reg_write;
  logic                  out_mem_read;
  logic                  out_mem_write;
  logic                  out_mem_to_reg;
  logic                  out_branch_taken;

  modport master (
    output in_valid, alu_result, alu_zero, alu_overflow, ovf_trap_en, pc, store_data,
           rd_addr, reg_write, mem_read, mem_write, mem_to_reg, branch,
    input  out_valid, out_result, out_zero, out_store_data, out_rd, out_reg_write,
           out_mem_read, out_mem_write, out_mem_to_reg, out_branch_taken
  );

  modport slave (
    input  in_valid, alu_result, alu_zero, alu_overflow, ovf_trap_en, pc, store_data,
           rd_addr, reg_write, mem_read, mem_write, mem_to_reg, branch,
    output out_valid, out_result, out_zero, out_store_data, out_rd, out_reg_write,
           out_mem_read, out_mem_write, out_mem_to_reg, out_branch_taken
  );
endinterface

// File: rtl/ex_exc_capture.sv
// Sticky overflow-exception tracker: IDLE/PENDING FSM plus the faulting PC (exc_epc).
// Not subject to the pipeline stall so the handler's acknowledge is never lost.
module ex_exc_capture #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kill,
  input  logic         exc_ack,
  input  logic [N-1:0] pc,
  output logic         exc_pending,
  output logic [N-1:0] exc_epc
);
  import ex_mem_stage_pkg::*;

  exc_state_t   state_q, state_d;
  logic         epc_load;
  logic [N-1:0] epc_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EXC_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: defaults first, so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    epc_load = 1'b0;
    case (state_q)
      EXC_IDLE: begin
        if (kill) begin
          state_d  = EXC_PENDING;
          epc_load = 1'b1;
        end
      end
      EXC_PENDING: begin
        // A new fault racing the ack wins: stay pending and record the newer PC.
        if (kill)         epc_load = exc_ack;
        else if (exc_ack) state_d  = EXC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        epc_q <= '0;
    else if (epc_load) epc_q <= pc;
  end

  assign exc_pending = (state_q == EXC_PENDING);
  assign exc_epc     = epc_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU result/flags and the control bundle, with
// flush > stall > load priority, overflow kill, and a retired-instruction counter.
module ex_mem_stage #(
  parameter int N          = 32,
  parameter int REG_ADDR_W = ex_mem_stage_pkg::REG_ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          exc_ack,
  ex_mem_stage_if.slave bus,
  output logic          exc_pending,
  output logic [N-1:0]  exc_epc,
  output logic [N-1:0]  insn_count
);
  import ex_mem_stage_pkg::*;

  logic                  load;
  logic                  kill;
  logic                  faulting;
  ctrl_t                 ctrl_in;
  ctrl_t                 ctrl_q;
  logic                  valid_q;
  logic [N-1:0]          result_q;
  logic                  zero_q;
  logic [N-1:0]          store_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [N-1:0]          count_q;

  assign load     = !flush && !stall;
  assign faulting = bus.ovf_trap_en && bus.alu_overflow;
  assign kill     = load && bus.in_valid && faulting;

  // Bubbles and trapping instructions enter MEM with every control cleared.
  always_comb begin
    ctrl_in = '0;
    if (bus.in_valid && !faulting) begin
      ctrl_in[CTRL_REG_WRITE]  = bus.reg_write;
      ctrl_in[CTRL_MEM_READ]   = bus.mem_read;
      ctrl_in[CTRL_MEM_WRITE]  = bus.mem_write;
      ctrl_in[CTRL_MEM_TO_REG] = bus.mem_to_reg;
      ctrl_in[CTRL_BRANCH]     = bus.branch && bus.alu_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      store_q  <= '0;
      rd_q     <= '0;
      count_q  <= '0;
    end else if (flush) begin
      // Flush squashes only validity and controls; data stays for debug visibility.
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (!stall) begin
      valid_q  <= bus.in_valid && !kill;
      ctrl_q   <= ctrl_in;
      result_q <= bus.alu_result;
      zero_q   <= bus.alu_zero;
      store_q  <= bus.store_data;
      rd_q     <= bus.rd_addr;
      if (bus.in_valid && !kill) count_q <= count_q + N'(1);
    end
  end

  ex_exc_capture #(.N(N)) u_exc_capture (
    .clk         (clk),
    .rst_n       (rst_n),
    .kill        (kill),
    .exc_ack     (exc_ack),
    .pc          (bus.pc),
    .exc_pending (exc_pending),
    .exc_epc     (exc_epc)
  );

  assign bus.out_valid        = valid_q;
  assign bus.out_result       = result_q;
  assign bus.out_zero         = zero_q;
  assign bus.out_store_data   = store_q;
  assign bus.out_rd           = rd_q;
  assign bus.out_reg_write    = ctrl_q[CTRL_REG_WRITE];
  assign bus.out_mem_read     = ctrl_q[CTRL_MEM_READ];
  assign bus.out_mem_write    = ctrl_q[CTRL_MEM_WRITE];
  assign bus.out_mem_to_reg   = ctrl_q[CTRL_MEM_TO_REG];
  assign bus.out_branch_taken = ctrl_q[CTRL_BRANCH];
  assign insn_count           = count_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: table of per-cycle vectors fed through a scoreboard,
// plus hand-written reset and counter-wrap sequences (wrap uses a narrow N=8 instance).
module tb_ex_mem_stage;

  typedef struct packed {
    logic        stall, flush, in_valid;
    logic [31:0] alu_result;
    logic        alu_zero, alu_overflow, ovf_trap_en;
    logic [31:0] pc, store_data;
    logic [4:0]  rd;
    logic        rw, mr, mw, m2r, br, ack;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic        zero;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        rw, mr, mw, m2r, bt;
    logic        pend;
    logic [31:0] epc;
    logic [31:0] cnt;
  } obs_t;

  typedef struct {
    string name;
    stim_t s;
    obs_t  e;
  } vec_t;

  typedef struct {
    string name;
    obs_t  e;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, exc_ack;
  logic        exc_pending;
  logic [31:0] exc_epc, insn_count;

  logic        stall8, flush8, exc_ack8;
  logic        exc_pending8;
  logic [7:0]  exc_epc8, insn_count8;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];
  exp_t sb_q[$];

  ex_mem_stage_if #(.N(32), .REG_ADDR_W(5)) bus ();
  ex_mem_stage_if #(.N(8),  .REG_ADDR_W(5)) bus8 ();

  ex_mem_stage #(.N(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .exc_ack(exc_ack),
    .bus(bus), .exc_pending(exc_pending), .exc_epc(exc_epc), .insn_count(insn_count)
  );

  ex_mem_stage #(.N(8), .REG_ADDR_W(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .stall(stall8), .flush(flush8), .exc_ack(exc_ack8),
    .bus(bus8), .exc_pending(exc_pending8), .exc_epc(exc_epc8), .insn_count(insn_count8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t st(input logic s, f, v, input logic [31:0] res, input logic z, o, t,
                               input logic [31:0] pc, sd, input logic [4:0] rd,
                               input logic rw, mr, mw, m2r, br, ack);
    stim_t x;
    x = '{s, f, v, res, z, o, t, pc, sd, rd, rw, mr, mw, m2r, br, ack};
    return x;
  endfunction

  function automatic obs_t ob(input logic v, input logic [31:0] res, input logic z,
                              input logic [31:0] sd, input logic [4:0] rd,
                              input logic rw, mr, mw, m2r, bt, pend,
                              input logic [31:0] epc, cnt);
    obs_t x;
    x = '{v, res, z, sd, rd, rw, mr, mw, m2r, bt, pend, epc, cnt};
    return x;
  endfunction

  function automatic obs_t sample();
    obs_t x;
    x = '{bus.out_valid, bus.out_result, bus.out_zero, bus.out_store_data, bus.out_rd,
          bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_mem_to_reg,
          bus.out_branch_taken, exc_pending, exc_epc, insn_count};
    return x;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    stall            = s.stall;
    flush            = s.flush;
    exc_ack          = s.ack;
    bus.in_valid     = s.in_valid;
    bus.alu_result   = s.alu_result;
    bus.alu_zero     = s.alu_zero;
    bus.alu_overflow = s.alu_overflow;
    bus.ovf_trap_en  = s.ovf_trap_en;
    bus.pc           = s.pc;
    bus.store_data   = s.store_data;
    bus.rd_addr      = s.rd;
    bus.reg_write    = s.rw;
    bus.mem_read     = s.mr;
    bus.mem_write    = s.mw;
    bus.mem_to_reg   = s.m2r;
    bus.branch       = s.br;
  endtask

  task automatic add(input string name, input stim_t s, input obs_t e);
    vec_t v;
    v.name = name;
    v.s    = s;
    v.e    = e;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    exp_t x;
    drive(v.s);
    sb_q.push_back('{v.name, v.e});
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check(x.name, sample(), x.e);
  endtask

  initial begin
    rst_n    = 1'b0;
    stall8   = 1'b0;
    flush8   = 1'b0;
    exc_ack8 = 1'b0;
    bus8.in_valid = 1'b0; bus8.alu_result = '0; bus8.alu_zero = 1'b0; bus8.alu_overflow = 1'b0;
    bus8.ovf_trap_en = 1'b0; bus8.pc = '0; bus8.store_data = '0; bus8.rd_addr = '0;
    bus8.reg_write = 1'b0; bus8.mem_read = 1'b0; bus8.mem_write = 1'b0;
    bus8.mem_to_reg = 1'b0; bus8.branch = 1'b0;
    drive('0);

    //      name            s f v result        z o t pc     sd       rd rw mr mw m2r br ack
    add("load",        st(0,0,1,32'h5,       0,0,0,32'h10,32'hAA,  3, 1,0,0,0,0,0), ob(1,32'h5,0,32'hAA,3, 1,0,0,0,0, 0,32'h0,1));
    add("load_lw",     st(0,0,1,32'h1234,    0,0,0,32'h14,32'hBB,  7, 1,1,0,1,0,0), ob(1,32'h1234,0,32'hBB,7, 1,1,0,1,0, 0,32'h0,2));
    add("stall1",      st(1,0,1,32'hDEAD,    0,0,0,32'h18,32'hCC,  9, 1,0,1,0,0,0), ob(1,32'h1234,0,32'hBB,7, 1,1,0,1,0, 0,32'h0,2));
    add("stall2",      st(1,0,1,32'hBEEF,    1,1,1,32'h1C,32'hDD, 10, 0,0,0,0,1,0), ob(1,32'h1234,0,32'hBB,7, 1,1,0,1,0, 0,32'h0,2));
    add("flush_stall", st(1,1,1,32'h5555,    1,0,0,32'h20,32'hEE, 11, 1,1,1,1,1,0), ob(0,32'h1234,0,32'hBB,7, 0,0,0,0,0, 0,32'h0,2));
    add("bubble",      st(0,0,0,32'h77,      1,0,0,32'h24,32'h11,  4, 1,0,1,0,1,0), ob(0,32'h77,1,32'h11,4, 0,0,0,0,0, 0,32'h0,2));
    add("store",       st(0,0,1,32'h100,     0,0,0,32'h28,32'hCAFE,0, 0,0,1,0,0,0), ob(1,32'h100,0,32'hCAFE,0, 0,0,1,0,0, 0,32'h0,3));
    add("beq_taken",   st(0,0,1,32'h0,       1,0,0,32'h2C,32'h0,   0, 0,0,0,0,1,0), ob(1,32'h0,1,32'h0,0, 0,0,0,0,1, 0,32'h0,4));
    add("beq_not",     st(0,0,1,32'h3,       0,0,0,32'h30,32'h0,   0, 0,0,0,0,1,0), ob(1,32'h3,0,32'h0,0, 0,0,0,0,0, 0,32'h0,5));
    add("zero_nobr",   st(0,0,1,32'h0,       1,0,0,32'h34,32'h0,   5, 1,0,0,0,0,0), ob(1,32'h0,1,32'h0,5, 1,0,0,0,0, 0,32'h0,6));
    add("addu_ovf",    st(0,0,1,32'h8000_0000,0,1,0,32'h38,32'h0,  8, 1,0,0,0,0,0), ob(1,32'h8000_0000,0,32'h0,8, 1,0,0,0,0, 0,32'h0,7));
    add("ovf_flush",   st(0,1,1,32'h8000_0000,0,1,1,32'h3C,32'h5,  9, 1,0,0,0,0,0), ob(0,32'h8000_0000,0,32'h0,8, 0,0,0,0,0, 0,32'h0,7));
    add("ovf_stall",   st(1,0,1,32'h8000_0000,0,1,1,32'h3C,32'h5,  9, 1,0,0,0,0,0), ob(0,32'h8000_0000,0,32'h0,8, 0,0,0,0,0, 0,32'h0,7));
    add("trap",        st(0,0,1,32'h8000_0000,0,1,1,32'h40,32'h1, 10, 1,0,0,0,0,0), ob(0,32'h8000_0000,0,32'h1,10, 0,0,0,0,0, 1,32'h40,7));
    add("trap2_keep",  st(0,0,1,32'h9,       0,1,1,32'h44,32'h2,  11, 1,0,1,0,0,0), ob(0,32'h9,0,32'h2,11, 0,0,0,0,0, 1,32'h40,7));
    add("valid_pend",  st(0,0,1,32'h42,      0,0,0,32'h4C,32'h0,  12, 1,0,0,0,0,0), ob(1,32'h42,0,32'h0,12, 1,0,0,0,0, 1,32'h40,8));
    add("ack_race",    st(0,0,1,32'hF,       0,1,1,32'h48,32'h3,  13, 1,0,0,0,0,1), ob(0,32'hF,0,32'h3,13, 0,0,0,0,0, 1,32'h48,8));
    add("ack_stall",   st(1,0,1,32'h99,      0,0,0,32'h50,32'h4,  14, 1,0,0,0,0,1), ob(0,32'hF,0,32'h3,13, 0,0,0,0,0, 0,32'h48,8));
    add("idle_ack",    st(0,0,0,32'h0,       0,0,0,32'h0, 32'h0,   0, 0,0,0,0,0,1), ob(0,32'h0,0,32'h0,0, 0,0,0,0,0, 0,32'h48,8));
    add("trap3",       st(0,0,1,32'h21,      0,1,1,32'h50,32'h0,  14, 1,0,0,0,0,0), ob(0,32'h21,0,32'h0,14, 0,0,0,0,0, 1,32'h50,8));
    add("ack_plain",   st(0,0,1,32'h22,      0,0,0,32'h54,32'h0,  15, 1,0,0,0,0,1), ob(1,32'h22,0,32'h0,15, 1,0,0,0,0, 0,32'h50,9));
    add("trap_stall",  st(1,0,1,32'h23,      0,1,1,32'h60,32'h0,  16, 1,0,0,0,0,0), ob(1,32'h22,0,32'h0,15, 1,0,0,0,0, 0,32'h50,9));
    add("trap4",       st(0,0,1,32'h33,      0,1,1,32'h70,32'h0,  16, 1,0,0,0,0,0), ob(0,32'h33,0,32'h0,16, 0,0,0,0,0, 1,32'h70,9));

    // Reset held across edges, then released with idle inputs.
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", sample(), '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", sample(), '0);

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset mid-cycle with a pending exception and nonzero counter.
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", sample(), '0);
    drive('0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset", sample(), '0);

    // Counter wrap on the narrow instance: 2^8-1 valid loads, then one more.
    bus8.in_valid = 1'b1;
    repeat (255) @(posedge clk);
    #1;
    check_val("cnt8_max", {24'h0, insn_count8}, 32'h0000_00FF);
    @(posedge clk);
    #1;
    check_val("cnt8_wrap", {24'h0, insn_count8}, 32'h0000_0000);
    bus8.in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
